// File: rtl/wave_sim_core.sv
// 1-D wave-equation solver: owns the u/du cell arrays and runs a requested
// number of Jacobi time steps, one interior cell per cycle, on a start/done handshake.
module wave_sim_core #(
   parameter int N_CELLS        = 20,
   parameter int DATA_W         = 32,
   parameter int COUPLING_SHIFT = 6,
   parameter int VEL_SHIFT      = 8,
   parameter int DAMP_MUL       = 2047,
   parameter int DAMP_SHIFT     = 11,
   parameter int ITER_W         = 16,
   localparam int ADDR_W        = $clog2(N_CELLS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ITER_W-1:0]          n_iter,
   input  logic                       boundary_mode,
   input  logic                       load_en,
   input  logic [ADDR_W-1:0]          load_addr,
   input  logic [DATA_W-1:0]          load_data,
   output logic [DATA_W-1:0]          rd_data,
   output logic [N_CELLS*DATA_W-1:0]  u_flat,
   output logic                       busy,
   output logic                       done,
   output logic [ITER_W-1:0]          iter_count
);

   localparam int EW = DATA_W + 3;
   localparam int PW = EW + 33;

   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [EW-1:0]     ext_t;
   typedef logic signed [PW-1:0]     prod_t;
   typedef enum logic [1:0] {IDLE, SWEEP, BOUND, FIN} state_t;

   localparam prod_t MAX_P = (prod_t'(1) <<< (DATA_W - 1)) - prod_t'(1);
   localparam prod_t MIN_P = -(prod_t'(1) <<< (DATA_W - 1));
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CELLS - 1);
   localparam logic [ADDR_W-1:0] PEN  = ADDR_W'(N_CELLS - 2);
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

   // Shifting the magnitude keeps small negative values from drifting to -1.
   function automatic ext_t shr_tz(input ext_t x, input int sh);
      ext_t mag;
      if (x[EW-1]) begin
         mag = -x;
         return -(mag >>> sh);
      end
      return x >>> sh;
   endfunction

   function automatic data_t sat_w(input prod_t x);
      if (x > MAX_P) return data_t'(MAX_P[DATA_W-1:0]);
      if (x < MIN_P) return data_t'(MIN_P[DATA_W-1:0]);
      return data_t'(x[DATA_W-1:0]);
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   data_t               ul_q, ul_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [ITER_W-1:0]   n_iter_q, n_iter_d;
   logic                mode_q, mode_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   data_t               u_q  [N_CELLS];
   data_t               u_d  [N_CELLS];
   data_t               du_q [N_CELLS];
   data_t               du_d [N_CELLS];

   data_t ul, ur, u_c, du_c, du_new, u_new;
   ext_t  lap, c, v;

   always_comb begin
      u_c    = u_q[idx_q];
      du_c   = du_q[idx_q];
      ur     = u_q[idx_q + ONE];
      ul     = (idx_q == ONE) ? u_q[0] : ul_q;
      lap    = ext_t'(ul) + ext_t'(ur) - (ext_t'(u_c) <<< 1);
      c      = shr_tz(lap, COUPLING_SHIFT);
      du_new = sat_w(prod_t'(ext_t'(du_c) + c));
      v      = shr_tz(ext_t'(du_new), VEL_SHIFT);
      u_new  = sat_w((prod_t'(ext_t'(u_c) + v) * prod_t'(DAMP_MUL)) >>> DAMP_SHIFT);
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ul_d     = ul_q;
      iter_d   = iter_q;
      n_iter_d = n_iter_q;
      mode_d   = mode_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      u_d      = u_q;
      du_d     = du_q;
      case (state_q)
         IDLE: begin
            // Load lands before a same-cycle start, so the run sees it.
            if (load_en && (load_addr <= LAST)) begin
               u_d[load_addr]  = data_t'(load_data);
               du_d[load_addr] = '0;
            end
            if (start) begin
               n_iter_d = n_iter;
               mode_d   = boundary_mode;
               iter_d   = '0;
               if (n_iter != '0) begin
                  state_d = SWEEP;
                  idx_d   = ONE;
                  busy_d  = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end
         SWEEP: begin
            ul_d         = u_c;
            u_d[idx_q]   = u_new;
            du_d[idx_q]  = du_new;
            if (idx_q == PEN) state_d = BOUND;
            else              idx_d   = idx_q + ONE;
         end
         BOUND: begin
            u_d[0]       = mode_q ? data_t'(0) : u_q[1];
            u_d[N_CELLS-1] = mode_q ? data_t'(0) : u_q[N_CELLS-2];
            iter_d       = iter_q + ITER_W'(1);
            if (iter_q + ITER_W'(1) == n_iter_q) begin
               state_d = FIN;
               busy_d  = 1'b0;
            end else begin
               state_d = SWEEP;
               idx_d   = ONE;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= ONE;
         ul_q     <= '0;
         iter_q   <= '0;
         n_iter_q <= '0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < N_CELLS; i++) begin
            u_q[i]  <= '0;
            du_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ul_q     <= ul_d;
         iter_q   <= iter_d;
         n_iter_q <= n_iter_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         for (int i = 0; i < N_CELLS; i++) begin
            u_q[i]  <= u_d[i];
            du_q[i] <= du_d[i];
         end
      end
   end

   always_comb begin
      u_flat = '0;
      for (int i = 0; i < N_CELLS; i++) u_flat[i*DATA_W +: DATA_W] = u_q[i];
   end

   assign rd_data    = (load_addr <= LAST) ? u_q[load_addr] : '0;
   assign busy       = busy_q;
   assign done       = done_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_wave_sim_core.sv
// Directed bench for wave_sim_core: two 5-cell instances share stimulus, one undamped
// (general behaviour) and one with zero coupling shift and real damping (saturation/rounding).
module tb_wave_sim_core;

   logic         clk = 1'b0;
   logic         rst, start, boundary_mode, load_en;
   logic [15:0]  n_iter;
   logic [2:0]   load_addr;
   logic [31:0]  load_data;

   logic [31:0]  rd_b, rd_s;
   logic [159:0] uf_b, uf_s;
   logic         busy_b, busy_s, done_b, done_s;
   logic [15:0]  ic_b, ic_s;

   int n_run  = 0;
   int n_fail = 0;

   wave_sim_core #(.N_CELLS(5), .DAMP_MUL(1), .DAMP_SHIFT(0)) dut_b (
      .clk(clk), .rst(rst), .start(start), .n_iter(n_iter), .boundary_mode(boundary_mode),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .rd_data(rd_b),
      .u_flat(uf_b), .busy(busy_b), .done(done_b), .iter_count(ic_b));

   wave_sim_core #(.N_CELLS(5), .COUPLING_SHIFT(0)) dut_s (
      .clk(clk), .rst(rst), .start(start), .n_iter(n_iter), .boundary_mode(boundary_mode),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .rd_data(rd_s),
      .u_flat(uf_s), .busy(busy_s), .done(done_s), .iter_count(ic_s));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [159:0] f5(input logic [31:0] a, b, c, d, e);
      return {e, d, c, b, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
   endtask

   task automatic load(input logic [2:0] a, input logic [31:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic load_all(input logic [31:0] d);
      for (int i = 0; i < 5; i++) load(3'(i), d);
   endtask

   task automatic launch(input int n, input logic mode);
      n_iter = 16'(n); boundary_mode = mode; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 2000; k++) begin
         tick();
         if (done_b) begin
            lat = k;
            break;
         end
      end
   endtask

   int lat, ndone, first;

   initial begin
      rst = 1'b1; start = 1'b0; n_iter = '0; boundary_mode = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_busy", busy_b, 0);
      check("rst_done", done_b, 0);
      check("rst_iter", ic_b, 0);
      check("rst_uflat", uf_b, 0);

      // load and readback
      load(3'd2, 32'd6400);
      load(3'd4, 32'hFFFFFFF9);
      load_addr = 3'd2; #1;
      check("rd_addr2", rd_b, 32'd6400);
      load_addr = 3'd4; #1;
      check("rd_addr4", rd_b, 32'hFFFFFFF9);
      check("load_uflat", uf_b, f5(0, 0, 32'd6400, 0, 32'hFFFFFFF9));

      // load while busy is ignored
      do_reset();
      launch(2, 1'b0);
      tick();
      load_en = 1'b1; load_addr = 3'd2; load_data = 32'd12345;
      tick(); tick();
      load_en = 1'b0;
      wait_done(lat);
      check("busy_load_uflat", uf_b, 0);

      // single step, undamped
      do_reset();
      load(3'd2, 32'd6400);
      launch(1, 1'b0);
      wait_done(lat);
      check("step_latency", lat, 5);
      check("step_iter", ic_b, 1);
      check("step_uflat", uf_b, f5(0, 0, 32'd6400, 0, 0));
      check("step_du0", $unsigned(dut_b.du_q[0]), 0);
      check("step_du1", $unsigned(dut_b.du_q[1]), 32'd100);
      check("step_du2", $unsigned(dut_b.du_q[2]), 32'hFFFFFF38);
      check("step_du3", $unsigned(dut_b.du_q[3]), 32'd100);
      check("step_du4", $unsigned(dut_b.du_q[4]), 0);
      tick();
      check("step_done_1cyc", done_b, 0);
      check("step_busy_low", busy_b, 0);

      // fixed and free boundary on a flat field
      do_reset();
      load_all(32'd500);
      launch(1, 1'b1);
      wait_done(lat);
      check("fixed_uflat", uf_b, f5(0, 32'd500, 32'd500, 32'd500, 0));
      check("fixed_du1", $unsigned(dut_b.du_q[1]), 0);
      check("fixed_du2", $unsigned(dut_b.du_q[2]), 0);
      check("fixed_du3", $unsigned(dut_b.du_q[3]), 0);
      load_all(32'd500);
      launch(1, 1'b0);
      wait_done(lat);
      check("free_uflat", uf_b, f5(32'd500, 32'd500, 32'd500, 32'd500, 32'd500));

      // lap = -1 rounds toward zero
      do_reset();
      load(3'd3, 32'hFFFFFFFF);
      launch(1, 1'b0);
      wait_done(lat);
      check("lapm1_du2", $unsigned(dut_b.du_q[2]), 0);
      check("lapm1_du3", $unsigned(dut_b.du_q[3]), 0);
      check("lapm1_uflat", uf_b, f5(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF));

      // saturation with Jacobi neighbour and floor damping
      do_reset();
      load(3'd1, 32'h7FFFFFFF);
      load(3'd2, 32'h80000000);
      load(3'd3, 32'h7FFFFFFF);
      launch(1, 1'b0);
      wait_done(lat);
      check("sat_du1", $unsigned(dut_s.du_q[1]), 32'h80000000);
      check("sat_du2", $unsigned(dut_s.du_q[2]), 32'h7FFFFFFF);
      check("sat_du3", $unsigned(dut_s.du_q[3]), 32'h80000000);
      check("sat_uflat", uf_s, f5(32'h7F700FFF, 32'h7F700FFF, 32'h808FEFFF, 32'h7F700FFF, 32'h7F700FFF));

      // damping rounds toward -inf
      do_reset();
      load_all(32'd1000);
      launch(1, 1'b0);
      wait_done(lat);
      check("damp_pos", uf_s, f5(32'd999, 32'd999, 32'd999, 32'd999, 32'd999));
      load_all(32'hFFFFFC18);
      launch(1, 1'b0);
      wait_done(lat);
      check("damp_neg", uf_s, f5(32'hFFFFFC18, 32'hFFFFFC18, 32'hFFFFFC18, 32'hFFFFFC18, 32'hFFFFFC18));

      // reset mid-run
      do_reset();
      load(3'd2, 32'd6400);
      launch(10, 1'b0);
      for (int k = 0; k < 200 && ic_b != 16'd3; k++) tick();
      check("mid_reach3", ic_b, 3);
      tick(); tick();
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy_b, 0);
      check("mid_rst_done", done_b, 0);
      check("mid_rst_iter", ic_b, 0);
      check("mid_rst_uflat", uf_b, 0);
      #1;
      rst = 1'b0;
      tick();
      launch(1, 1'b0);
      wait_done(lat);
      check("post_rst_latency", lat, 5);
      check("post_rst_iter", ic_b, 1);

      // n_iter = 0
      do_reset();
      load(3'd2, 32'd6400);
      launch(0, 1'b0);
      wait_done(lat);
      check("zero_latency", lat, 1);
      check("zero_busy", busy_b, 0);
      check("zero_uflat", uf_b, f5(0, 0, 32'd6400, 0, 0));

      // start while busy is ignored
      launch(4, 1'b0);
      ndone = 0; first = -1;
      for (int k = 1; k <= 40; k++) begin
         start  = (k == 3 || k == 10);
         n_iter = 16'd7;
         tick();
         start = 1'b0;
         if (done_b) begin
            ndone++;
            if (first < 0) first = k;
         end
      end
      check("hs_done_count", ndone, 1);
      check("hs_latency", first, 17);
      check("hs_iter", ic_b, 4);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/wave_sim_core.md
Name: wave_sim_core

Overview:
Parametrised 1-D wave-equation solver that owns the u/du state arrays for N_CELLS cells. It runs a requested number of time-step iterations on a start/done handshake. It is the successor to the fixed 20-cell, free-running solver loop in top. It adds signed saturating arithmetic, a selectable boundary mode, a host load/readback path, and a flat snapshot output for the UART array transmitter.

Parameters:
N_CELLS, 20, number of cells (>=3)
DATA_W, 32, signed two's-complement width of u and du
COUPLING_SHIFT, 6, right shift applied to the Laplacian before adding to du
VEL_SHIFT, 8, right shift applied to du before adding to u
DAMP_MUL, 2047, damping multiplier
DAMP_SHIFT, 11, damping right shift (DAMP_MUL/2^DAMP_SHIFT = damping factor)
ITER_W, 16, width of the iteration count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to run n_iter iterations
n_iter  in  ITER_W  iterations to run, sampled when start is accepted
boundary_mode  in  1  0 = free (edge copies neighbour), 1 = fixed (edge forced to 0); sampled at start
load_en  in  1  write load_data to u[load_addr] and clear du[load_addr]
load_addr  in  $clog2(N_CELLS)  load/readback cell index
load_data  in  DATA_W  initial u value
rd_data  out  DATA_W  u[load_addr], combinational
u_flat  out  N_CELLS*DATA_W  all u values, cell i at bits [i*DATA_W +: DATA_W]
busy  out  1  high while iterating
done  out  1  one-cycle pulse when the run completes
iter_count  out  ITER_W  iterations completed in the current or last run

Behaviour:
- Reset (async, any state): all u and du = 0, state IDLE, busy=0, done=0, iter_count=0. Reset mid-run aborts immediately with no partial-cycle write.
- FSM states: IDLE, SWEEP, BOUND, FIN.
  - IDLE: load_en is honoured. start with n_iter>0 → SWEEP: cell index i=1, iter_count=0, busy=1 from the next cycle. start with n_iter=0 → FIN directly, with no state change.
  - SWEEP: one cell per cycle, i = 1 .. N_CELLS-2. After i = N_CELLS-2 → BOUND.
  - BOUND: one cycle. Mode 0: u[0] ← new u[1], u[N-1] ← new u[N-2]. Mode 1: u[0] = u[N-1] = 0. du of the edge cells is unchanged. iter_count increments. If iter_count+1 == n_iter → FIN, else back to SWEEP at i=1.
  - FIN: done=1 for exactly one cycle, busy=0, → IDLE.
- Each iteration takes N_CELLS-1 cycles. With start accepted at edge 0, done is high for the cycle after edge n_iter*(N_CELLS-1)+1.
- Update is Jacobi: uL is the pre-update value of u[i-1], held in a one-entry register before the overwrite. uR = u[i+1] is not yet updated.
- Per-cell arithmetic, computed at DATA_W+3 bits signed:
  - lap = uL + uR - 2u
  - c = lap shifted right by COUPLING_SHIFT, rounded toward zero (so -1 contributes 0 and there is no drift)
  - du' = sat(du + c)
  - v = du' shifted right by VEL_SHIFT, rounded toward zero
  - u' = sat(((u + v) * DAMP_MUL) >>> DAMP_SHIFT), using the full-width product and rounding toward -inf
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Both u' and du' are written in the same cycle.
- Ignored inputs: start while busy or during FIN; load_en while not IDLE. n_iter and boundary_mode are latched at start.
- load_en and start in the same IDLE cycle: the load is applied first, then the run starts on the loaded data.
- rd_data and u_flat reflect the array every cycle, including mid-run. The consumer samples them after done.

Test Plan:
1. Reset check: assert rst mid-run (iter 3 of 10) → busy=0, done=0, iter_count=0, u_flat=0 on the same cycle. After release, start with n_iter=1 runs normally.
2. Load and readback: load u[2]=6400, u[4]=-7 → rd_data at addr 2 = 6400, addr 4 = 0xFFFFFFF9, all other cells 0. Also assert load_en while busy → array unchanged.
3. Single step, no damping (N_CELLS=5, DAMP_MUL=1, DAMP_SHIFT=0), u=[0,0,6400,0,0], du=0, n_iter=1, mode 0:
   - du=[0,100,-200,100,0], u unchanged.
   - done pulses exactly 5 cycles after the start edge.
   - iter_count=1.
4. Fixed boundary (N=5), u=[500,500,500,500,500], mode 1, n_iter=1:
   - u=[0,500,500,500,0].
   - du[1]=du[2]=du[3]=0, since lap=0 during the sweep.
   - Mode 0 with the same load: u stays at 500 everywhere.
5. Saturation and rounding:
   - u[1]=u[3]=0x7FFFFFFF, u[2]=0x80000000, COUPLING_SHIFT=0 → du[2] = 0x7FFFFFFF with no wrap.
   - Separately, lap=-1 with COUPLING_SHIFT=6 → du stays 0.
6. Handshake:
   - start with n_iter=0 → done pulse next cycle, array unchanged.
   - start pulsed while busy in a 4-iteration run → exactly one done, iter_count=4, run length 4*(N_CELLS-1)+1 cycles.
